antares_hilo_unit: RTL and testbench
====================================

Name: antares_hilo_unit

Overview:
- HI/LO register unit and multiply sequencer. Sits between the EX stage and the 4-stage pipelined multiplier. Consumes the multiplier's 64-bit result.
- Issues MULT/MULTU/MADD/MADDU/MSUB/MSUBU to the multiplier and tracks the in-flight operation.
- Accumulates or overwrites HI:LO when the result returns. Serves MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall when an instruction touches HI/LO while a multiply is in flight.

Parameters:
- MULT_LATENCY, 4, edges from the issue edge to mult_ready high. Informational; completion uses mult_ready, not a counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  EX holds a valid HI/LO-class instruction
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 MADD, 4 MADDU, 5 MSUB, 6 MSUBU, 7 MTHI, 8 MTLO, 9 MFHI, 10 MFLO; 11-15 treated as NOP
- rs_data  in  32  operand A / MTHI/MTLO data
- rt_data  in  32  operand B
- ex_stall  in  1  EX frozen by another source; no issue, no write
- flush  in  1  discard in-flight op
- hilo_read_data  out  32  HI (MFHI) or LO (MFLO), else 0
- hilo_stall  out  1  stall request to hazard unit
- mult_input_a  out  32  to multiplier
- mult_input_b  out  32  to multiplier
- mult_signed_op  out  1  to multiplier
- mult_enable_op  out  1  to multiplier, one-cycle issue pulse
- mult_flush  out  1  to multiplier flush
- mult_result  in  64  from multiplier (sign already applied)
- mult_ready  in  1  from multiplier, result valid

Behaviour:
- State: IDLE, BUSY. Registers: hi[31:0], lo[31:0], acc_mode[1:0] (NONE/ADD/SUB).
- Reset values: state IDLE, hi=lo=0, acc_mode NONE. hilo_stall=0, mult_enable_op=0, mult_flush=1 while rst is high.
- Integration ties the multiplier's mult_stall low. The multiplier always runs freely.
- issue = op_valid & op∈{1..6} & state==IDLE & ~ex_stall & ~flush.
- issue drives mult_enable_op=1 combinationally, with mult_input_a=rs_data, mult_input_b=rt_data, mult_signed_op=1 for op∈{1,3,5}.
- mult_input_a/b and mult_signed_op pass through combinationally at all times. mult_enable_op=0 when issue is false.
- On an issue edge: state BUSY, acc_mode = NONE (1,2), ADD (3,4) or SUB (5,6).
- BUSY & mult_ready & ~flush, at the next edge:
  - NONE: {hi,lo}<=mult_result.
  - ADD: {hi,lo}<={hi,lo}+mult_result.
  - SUB: {hi,lo}<={hi,lo}-mult_result.
  - All 64-bit modulo 2^64. State returns to IDLE.
- Timing: issue edge E0, mult_ready high after E3, HI/LO written at E4. An op may issue in the cycle after E4. No back-to-back issue while BUSY.
- mult_ready while IDLE is ignored (stale/flushed result).
- hilo_stall = op_valid & state==BUSY & op∈{1..10}. Non-HI/LO instructions never stall; the multiply runs in the background.
- MTHI/MTLO: hi or lo <= rs_data at an edge with op_valid & state==IDLE & ~ex_stall & ~flush.
- MFHI/MFLO: combinational read of the current hi/lo. Valid only when hilo_stall=0. The new value is visible the cycle after the write edge; no bypass of the result written at E4.
- flush: mult_flush=flush|rst. State goes to IDLE, acc_mode NONE, hi/lo unchanged, no issue in that cycle.
- flush in the same cycle as mult_ready: flush wins; no HI/LO write.
- ex_stall while BUSY does not delay completion. The HI/LO write still occurs at E4.
- rst mid-operation: same as flush, plus hi=lo=0.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> mult_enable_op pulse one cycle; after E4 hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE. MTHI 0 / MTLO 5, then MADD 3,4 -> hi=0, lo=0x11.
- hi=lo=0, MSUBU 1,1 -> hi=lo=0xFFFFFFFF. MADDU 0xFFFFFFFF,0xFFFFFFFF onto hi=0, lo=1 -> hi=0xFFFFFFFE, lo=0x00000002.
- MULT issued, MFLO presented the next cycle -> hilo_stall=1 for cycles E1..E3 and the E4 edge cycle; 0 afterwards; read returns the new lo.
- MULT 7,7 then flush two cycles later -> mult_flush pulse, state IDLE, hi/lo keep old values; stale mult_ready ignored.
- Issue attempted with ex_stall=1 -> no mult_enable_op. Later MTLO with a mult in flight -> stalls, then lo=rs_data after completion.

Source files
------------

// File: rtl/antares_hilo_unit.sv
// HI/LO register unit: issues multiplies to the external pipelined multiplier, folds the
// returning 64-bit product into HI:LO and stalls HI/LO consumers while a multiply is in flight.
module antares_hilo_unit #(
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] rs_data_i,
    input  logic [31:0] rt_data_i,
    input  logic        ex_stall_i,
    input  logic        flush_i,
    output logic [31:0] hilo_read_data_o,
    output logic        hilo_stall_o,
    output logic [31:0] mult_input_a_o,
    output logic [31:0] mult_input_b_o,
    output logic        mult_signed_op_o,
    output logic        mult_enable_op_o,
    output logic        mult_flush_o,
    input  logic [63:0] mult_result_i,
    input  logic        mult_ready_i
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpMadd  = 4'd3;
    localparam logic [3:0] OpMaddu = 4'd4;
    localparam logic [3:0] OpMsub  = 4'd5;
    localparam logic [3:0] OpMsubu = 4'd6;
    localparam logic [3:0] OpMthi  = 4'd7;
    localparam logic [3:0] OpMtlo  = 4'd8;
    localparam logic [3:0] OpMfhi  = 4'd9;
    localparam logic [3:0] OpMflo  = 4'd10;

    localparam int unsigned AgeW = $clog2(MULT_LATENCY + 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;
    typedef enum logic [1:0] {AccNone, AccAdd, AccSub} acc_e;

    state_e            state_q, state_d;
    acc_e              acc_q, acc_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [AgeW-1:0]   age_q, age_d;

    logic              is_mul_op;
    logic              is_signed_op;
    logic              is_hilo_op;
    acc_e              op_acc;
    logic              idle;
    logic              issue;
    logic              mt_write;
    logic              complete;

    // Instruction decode
    always_comb begin
        is_mul_op    = 1'b0;
        is_signed_op = 1'b0;
        is_hilo_op   = 1'b0;
        op_acc       = AccNone;
        case (op_i)
            OpMult: begin
                is_mul_op    = 1'b1;
                is_signed_op = 1'b1;
                is_hilo_op   = 1'b1;
            end
            OpMultu: begin
                is_mul_op  = 1'b1;
                is_hilo_op = 1'b1;
            end
            OpMadd: begin
                is_mul_op    = 1'b1;
                is_signed_op = 1'b1;
                is_hilo_op   = 1'b1;
                op_acc       = AccAdd;
            end
            OpMaddu: begin
                is_mul_op  = 1'b1;
                is_hilo_op = 1'b1;
                op_acc     = AccAdd;
            end
            OpMsub: begin
                is_mul_op    = 1'b1;
                is_signed_op = 1'b1;
                is_hilo_op   = 1'b1;
                op_acc       = AccSub;
            end
            OpMsubu: begin
                is_mul_op  = 1'b1;
                is_hilo_op = 1'b1;
                op_acc     = AccSub;
            end
            OpMthi, OpMtlo, OpMfhi, OpMflo: begin
                is_hilo_op = 1'b1;
            end
            default: begin
                is_hilo_op = 1'b0;
            end
        endcase
    end

    assign idle     = (state_q == StIdle);
    assign issue    = op_valid_i & is_mul_op & idle & ~ex_stall_i & ~flush_i & ~rst;
    assign mt_write = op_valid_i & ((op_i == OpMthi) | (op_i == OpMtlo)) & idle
                      & ~ex_stall_i & ~flush_i;
    // A result arriving while idle belongs to a flushed op and is dropped.
    assign complete = (state_q == StBusy) & mult_ready_i & ~flush_i;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (flush_i || mult_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mult_input_a_o   = rs_data_i;
        mult_input_b_o   = rt_data_i;
        mult_signed_op_o = is_signed_op;
        mult_enable_op_o = issue;
        mult_flush_o     = flush_i | rst;
        hilo_stall_o     = op_valid_i & (state_q == StBusy) & is_hilo_op & ~rst;
        hilo_read_data_o = '0;
        if (op_valid_i && op_i == OpMfhi) begin
            hilo_read_data_o = hi_q;
        end else if (op_valid_i && op_i == OpMflo) begin
            hilo_read_data_o = lo_q;
        end
    end

    // Accumulate mode and HI/LO next state
    always_comb begin
        acc_d = acc_q;
        if (flush_i) begin
            acc_d = AccNone;
        end else if (issue) begin
            acc_d = op_acc;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (complete) begin
            unique case (acc_q)
                AccAdd:  {hi_d, lo_d} = {hi_q, lo_q} + mult_result_i;
                AccSub:  {hi_d, lo_d} = {hi_q, lo_q} - mult_result_i;
                default: {hi_d, lo_d} = mult_result_i;
            endcase
        end else if (mt_write) begin
            if (op_i == OpMthi) begin
                hi_d = rs_data_i;
            end else begin
                lo_d = rs_data_i;
            end
        end
    end

    // Edges since issue; only used to sanity-check the multiplier's latency.
    always_comb begin
        age_d = age_q;
        if (issue) begin
            age_d = '0;
        end else if (state_q == StBusy && age_q != AgeW'(MULT_LATENCY)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= AccNone;
            hi_q  <= '0;
            lo_q  <= '0;
            age_q <= '0;
        end else begin
            acc_q <= acc_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            age_q <= age_d;
        end
    end

    assert property (@(posedge clk) disable iff (rst)
        (state_q == StBusy && mult_ready_i) |-> (age_q == AgeW'(MULT_LATENCY - 1)));

endmodule

// File: tb/tb_antares_hilo_unit.sv
// Randomized scoreboard bench for antares_hilo_unit with a 4-stage multiplier model and an
// architectural HI:LO reference model.
module tb_antares_hilo_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid_i = 1'b0;
    logic [3:0]  op_i = 4'd0;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        ex_stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] hilo_read_data_o;
    logic        hilo_stall_o;
    logic [31:0] mult_input_a_o;
    logic [31:0] mult_input_b_o;
    logic        mult_signed_op_o;
    logic        mult_enable_op_o;
    logic        mult_flush_o;
    logic [63:0] mult_result_i;
    logic        mult_ready_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    antares_hilo_unit #(.MULT_LATENCY(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .op_valid_i       (op_valid_i),
        .op_i             (op_i),
        .rs_data_i        (rs_data_i),
        .rt_data_i        (rt_data_i),
        .ex_stall_i       (ex_stall_i),
        .flush_i          (flush_i),
        .hilo_read_data_o (hilo_read_data_o),
        .hilo_stall_o     (hilo_stall_o),
        .mult_input_a_o   (mult_input_a_o),
        .mult_input_b_o   (mult_input_b_o),
        .mult_signed_op_o (mult_signed_op_o),
        .mult_enable_op_o (mult_enable_op_o),
        .mult_flush_o     (mult_flush_o),
        .mult_result_i    (mult_result_i),
        .mult_ready_i     (mult_ready_i)
    );

    function automatic logic [63:0] ext_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit sgn);
        logic [63:0] xa, xb;
        xa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        xb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        return xa * xb;
    endfunction

    // Multiplier: four register stages, ignores flush so stale results reach the DUT.
    logic [3:0]  pv = 4'b0;
    logic [63:0] pr [4];
    always @(posedge clk) begin
        pv    <= {pv[2:0], mult_enable_op_o};
        pr[3] <= pr[2];
        pr[2] <= pr[1];
        pr[1] <= pr[0];
        pr[0] <= mult_enable_op_o ? ext_mul(mult_input_a_o, mult_input_b_o, mult_signed_op_o)
                                  : {$urandom, $urandom};
    end
    assign mult_ready_i  = pv[3];
    assign mult_result_i = pr[3];

    // Architectural reference: HI:LO as a 64-bit number, updated when an op is accepted.
    function automatic logic [63:0] ref_op(input logic [63:0] hl, input int op,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = ext_mul(a, b, (op == 1 || op == 3 || op == 5));
        if (op == 3 || op == 4) return hl + p;
        if (op == 5 || op == 6) return hl - p;
        return p;
    endfunction

    logic [63:0] m_hl = '0;
    logic [63:0] m_bk = '0;
    int          m_cnt = 0;  // edges left until the in-flight product lands

    always @(posedge clk) begin
        if (rst) begin
            m_hl  <= '0;
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            if (flush_i) begin
                m_hl  <= m_bk;
                m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (op_valid_i && !ex_stall_i && !flush_i) begin
            if (op_i >= 4'd1 && op_i <= 4'd6) begin
                m_bk  <= m_hl;
                m_hl  <= ref_op(m_hl, int'(op_i), rs_data_i, rt_data_i);
                m_cnt <= 4;
            end else if (op_i == 4'd7) begin
                m_hl[63:32] <= rs_data_i;
            end else if (op_i == 4'd8) begin
                m_hl[31:0] <= rs_data_i;
            end
        end
    end

    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle control checks plus scoreboard pop on each accepted MFHI/MFLO.
    always @(negedge clk) begin
        check("hilo_stall", 64'(hilo_stall_o),
              64'(!rst && op_valid_i && m_cnt != 0 && op_i >= 4'd1 && op_i <= 4'd10));
        check("mult_enable", 64'(mult_enable_op_o),
              64'(!rst && op_valid_i && op_i >= 4'd1 && op_i <= 4'd6 && m_cnt == 0
                  && !ex_stall_i && !flush_i));
        check("mult_flush", 64'(mult_flush_o), 64'(flush_i || rst));
        if (mult_enable_op_o) begin
            check("mult_a", 64'(mult_input_a_o), 64'(rs_data_i));
            check("mult_b", 64'(mult_input_b_o), 64'(rt_data_i));
            check("mult_signed", 64'(mult_signed_op_o),
                  64'(op_i == 4'd1 || op_i == 4'd3 || op_i == 4'd5));
        end
        if (!rst && op_valid_i && (op_i == 4'd9 || op_i == 4'd10) && !hilo_stall_o) begin
            if (exp_q.size() == 0) begin
                check("read_unexpected", 64'(hilo_read_data_o), 64'hDEAD_0000_0000_0000);
            end else begin
                check(op_i == 4'd9 ? "mfhi" : "mflo", 64'(hilo_read_data_o),
                      64'(exp_q.pop_front()));
            end
        end else if (op_valid_i && op_i != 4'd9 && op_i != 4'd10) begin
            check("read_zero", 64'(hilo_read_data_o), 64'd0);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            op_valid_i = 1'b0; op_i = 4'd0; ex_stall_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
            cycle();
        end
    endtask

    task automatic instr(input int op, input logic [31:0] rs, input logic [31:0] rt,
                         input int nex);
        int waits;
        logic st;
        op_valid_i = 1'b1; op_i = 4'(op); rs_data_i = rs; rt_data_i = rt;
        flush_i = 1'b0; rst = 1'b0;
        if (op == 9) exp_q.push_back(m_hl[63:32]);
        if (op == 10) exp_q.push_back(m_hl[31:0]);
        for (int i = 0; i < nex; i++) begin
            ex_stall_i = 1'b1;
            cycle();
        end
        ex_stall_i = 1'b0;
        waits = 0;
        forever begin
            @(negedge clk);
            st = hilo_stall_o;
            cycle();
            if (!st) break;
            waits++;
            if (waits > 20) begin
                errors++;
                $display("FAIL hold_bound: op %0d still stalled after %0d cycles", op, waits);
                break;
            end
        end
    endtask

    task automatic do_flush();
        op_valid_i = 1'b0; op_i = 4'd0; ex_stall_i = 1'b0; flush_i = 1'b1; rst = 1'b0;
        cycle();
        nop(5);
    endtask

    task automatic do_rst();
        op_valid_i = 1'b0; op_i = 4'd0; ex_stall_i = 1'b0; flush_i = 1'b0; rst = 1'b1;
        cycle();
        nop(5);
    endtask

    initial begin
        int r, op, nex;
        logic [31:0] a, b;
        // Reset, with a multiply presented while rst is high
        rst = 1'b1;
        cycle();
        op_valid_i = 1'b1; op_i = 4'd1; rs_data_i = 32'd3; rt_data_i = 32'd4;
        cycle();
        nop(6);
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        // Directed cases
        instr(1, 32'hFFFF_FFFF, 32'h2, 0); instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(2, 32'hFFFF_FFFF, 32'h2, 0); instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(7, 0, 0, 0); instr(8, 5, 0, 0); instr(3, 3, 4, 0);
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(7, 0, 0, 0); instr(8, 0, 0, 0); instr(6, 1, 1, 0);
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(7, 0, 0, 0); instr(8, 1, 0, 0); instr(4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(1, 32'h1234, 32'h10, 0); instr(10, 0, 0, 0);
        instr(7, 32'h1234, 0, 0); instr(1, 7, 7, 0); nop(1); do_flush();
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(1, 11, 13, 2); instr(1, 3, 5, 0); instr(8, 32'hABCD, 0, 0);
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        instr(1, 9, 9, 0); nop(2); do_rst();
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        // Randomized traffic
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                do_flush();
            end else if (r < 7) begin
                do_rst();
            end else if (r < 17) begin
                nop(1);
            end else begin
                op = $urandom_range(0, 15);
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
                nex = (op != 9 && op != 10 && $urandom_range(0, 4) == 0) ? 1 : 0;
                instr(op, a, b, nex);
                if (op >= 1 && op <= 6 && $urandom_range(0, 9) < 3) begin
                    nop($urandom_range(0, 3));
                    do_flush();
                end
            end
        end
        instr(9, 0, 0, 0); instr(10, 0, 0, 0);
        nop(8);
        check("queue_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
